fwd_hazard_unit: RTL and testbench

Parametrised data-hazard controller for the RV32 pipeline, replacing the fixed two-source hazard/forwarding pair. It tracks the destination register of every in-flight instruction over NSTAGE post-decode stages. For each decode operand it selects the youngest valid producer or the register file. It raises a stall when the producer's result is not yet available, for example load-use. It sits between decode and exe, feeding the ALU operand inputs and the decode/fetch hold.

---
 rtl/haz_pkg.sv | 19 +
 rtl/haz_match.sv | 40 ++++
 rtl/fwd_hazard_unit.sv | 110 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/haz_pkg.sv
// haz_pkg: shared types and constants for the forwarding/hazard controller.
`default_nettype none

package haz_pkg;

  localparam int HAZ_AW     = 5;
  localparam int FWD_SEL_RF = 0;
  localparam int NSTAGE_MIN = 1;
  localparam int NSTAGE_MAX = 4;

  typedef struct packed {
    logic              valid;
    logic [HAZ_AW-1:0] rd;
    logic              wr;
  } haz_entry_t;

endpackage

`default_nettype wire

// File: rtl/haz_match.sv
// haz_match: per-operand priority matcher picking the youngest in-flight producer.
`default_nettype none

module haz_match
  import haz_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int NSTAGE = 3,
  parameter int SW     = $clog2(NSTAGE + 1)
) (
  input  logic [AW-1:0]          addr,
  input  logic                   used,
  input  haz_entry_t             entries [NSTAGE],
  input  logic [NSTAGE-1:0]      ok,
  input  logic [NSTAGE*XLEN-1:0] results,
  input  logic [XLEN-1:0]        rf_data,
  output logic [XLEN-1:0]        fwd,
  output logic [SW-1:0]          sel,
  output logic                   hazard
);

  // Scan oldest to youngest so the last hit, the lowest stage, wins.
  always_comb begin
    fwd    = rf_data;
    sel    = SW'(FWD_SEL_RF);
    hazard = 1'b0;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (used && (addr != '0) && entries[k].valid && entries[k].wr &&
          (entries[k].rd == addr)) begin
        sel    = SW'(k + 1);
        hazard = ~ok[k];
        fwd    = ok[k] ? results[k*XLEN +: XLEN] : rf_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: in-flight destination tracking, operand forwarding and load-use stall.
// Optional HAZ_WB_BYPASS_EN adds a writeback bypass for read-before-write register files.
`default_nettype none

module fwd_hazard_unit
  import haz_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int NSTAGE = 3,
  parameter int SW     = $clog2(NSTAGE + 1)
) (
  input  logic                   clk,
  input  logic                   rstn,
`ifdef HAZ_WB_BYPASS_EN
  input  logic                   wb_wr,
  input  logic [AW-1:0]          wb_addr,
  input  logic [XLEN-1:0]        wb_data,
`endif
  input  logic                   id_valid,
  input  logic [AW-1:0]          id_rs1_addr,
  input  logic [AW-1:0]          id_rs2_addr,
  input  logic                   id_rs1_used,
  input  logic                   id_rs2_used,
  input  logic [AW-1:0]          id_rd_addr,
  input  logic                   id_reg_wr,
  input  logic [XLEN-1:0]        id_rs1_data,
  input  logic [XLEN-1:0]        id_rs2_data,
  input  logic [NSTAGE*XLEN-1:0] stage_result,
  input  logic [NSTAGE-1:0]      stage_result_ok,
  input  logic                   adv,
  input  logic                   flush,
  output logic [XLEN-1:0]        rs1_fwd,
  output logic [XLEN-1:0]        rs2_fwd,
  output logic [SW-1:0]          fwd_sel1,
  output logic [SW-1:0]          fwd_sel2,
  output logic                   stall,
  output logic [31:0]            stall_cycles
);

  if (NSTAGE < NSTAGE_MIN || NSTAGE > NSTAGE_MAX) begin : g_bad_nstage
    $error("fwd_hazard_unit: NSTAGE out of range");
  end

  haz_entry_t      entries [NSTAGE];
  logic [XLEN-1:0] rs1_rf;
  logic [XLEN-1:0] rs2_rf;
  logic            rs1_hazard;
  logic            rs2_hazard;

`ifdef HAZ_WB_BYPASS_EN
  // Register file returns stale data during its own write; patch it here.
  assign rs1_rf = (wb_wr && (wb_addr == id_rs1_addr) && (id_rs1_addr != '0)) ? wb_data : id_rs1_data;
  assign rs2_rf = (wb_wr && (wb_addr == id_rs2_addr) && (id_rs2_addr != '0)) ? wb_data : id_rs2_data;
`else
  assign rs1_rf = id_rs1_data;
  assign rs2_rf = id_rs2_data;
`endif

  haz_match #(.XLEN(XLEN), .AW(AW), .NSTAGE(NSTAGE), .SW(SW)) u_match_rs1 (
    .addr    (id_rs1_addr),
    .used    (id_rs1_used),
    .entries (entries),
    .ok      (stage_result_ok),
    .results (stage_result),
    .rf_data (rs1_rf),
    .fwd     (rs1_fwd),
    .sel     (fwd_sel1),
    .hazard  (rs1_hazard)
  );

  haz_match #(.XLEN(XLEN), .AW(AW), .NSTAGE(NSTAGE), .SW(SW)) u_match_rs2 (
    .addr    (id_rs2_addr),
    .used    (id_rs2_used),
    .entries (entries),
    .ok      (stage_result_ok),
    .results (stage_result),
    .rf_data (rs2_rf),
    .fwd     (rs2_fwd),
    .sel     (fwd_sel2),
    .hazard  (rs2_hazard)
  );

  // A flushed decode slot never stalls; it simply becomes a bubble.
  assign stall = id_valid & ~flush & (rs1_hazard | rs2_hazard);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < NSTAGE; k++) begin
        entries[k] <= '0;
      end
    end else if (adv) begin
      entries[0] <= '{valid: id_valid & ~stall & ~flush, rd: id_rd_addr, wr: id_reg_wr};
      for (int k = 1; k < NSTAGE; k++) begin
        entries[k] <= entries[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: table vectors, hand-written sequences and randomized model check.
`default_nettype none

module tb_fwd_hazard_unit;

  localparam int XLEN = 32;
  localparam int NS   = 3;

  logic             clk = 1'b0;
  logic             rstn;
  logic             id_valid;
  logic [4:0]       id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic             id_rs1_used, id_rs2_used, id_reg_wr;
  logic [31:0]      id_rs1_data, id_rs2_data;
  logic [NS*32-1:0] stage_result;
  logic [NS-1:0]    stage_result_ok;
  logic             adv, flush;
  logic [31:0]      rs1_fwd, rs2_fwd;
  logic [1:0]       fwd_sel1, fwd_sel2;
  logic             stall;
  logic [31:0]      stall_cycles;

  int nchk  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.XLEN(XLEN), .AW(5), .NSTAGE(NS)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .id_valid        (id_valid),
    .id_rs1_addr     (id_rs1_addr),
    .id_rs2_addr     (id_rs2_addr),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .id_rd_addr      (id_rd_addr),
    .id_reg_wr       (id_reg_wr),
    .id_rs1_data     (id_rs1_data),
    .id_rs2_data     (id_rs2_data),
    .stage_result    (stage_result),
    .stage_result_ok (stage_result_ok),
    .adv             (adv),
    .flush           (flush),
    .rs1_fwd         (rs1_fwd),
    .rs2_fwd         (rs2_fwd),
    .fwd_sel1        (fwd_sel1),
    .fwd_sel2        (fwd_sel2),
    .stall           (stall),
    .stall_cycles    (stall_cycles)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
    id_rs1_used = 0; id_rs2_used = 0; id_reg_wr = 0;
    id_rs1_data = 32'h1234; id_rs2_data = 32'h5678;
    stage_result = {32'h22, 32'h77, 32'hA5}; stage_result_ok = '1;
    adv = 0; flush = 0;
  endtask

  task automatic do_reset();
    rstn = 0;
    @(negedge clk);
    rstn = 1;
  endtask

  // Inserts one instruction into stage 0, shifting older ones down.
  task automatic push(input logic v, input logic [4:0] rd, input logic wr);
    id_valid = v; id_rd_addr = rd; id_reg_wr = wr;
    id_rs1_used = 0; id_rs2_used = 0; adv = 1; flush = 0;
    @(negedge clk);
    adv = 0; id_valid = 0;
  endtask

  typedef struct {
    logic [2:0] pv, pwr; logic [14:0] prd;
    logic v, fl; logic [4:0] a1; logic u1; logic [4:0] a2; logic u2; logic [2:0] ok;
    logic [31:0] e1; logic c1; logic [1:0] s1;
    logic [31:0] e2; logic c2; logic [1:0] s2; logic st;
  } vec_t;

  function automatic vec_t mk(
      input logic [2:0] pv, input logic [2:0] pwr, input logic [14:0] prd,
      input logic v, input logic fl, input logic [4:0] a1, input logic u1,
      input logic [4:0] a2, input logic u2, input logic [2:0] ok,
      input logic [31:0] e1, input logic c1, input logic [1:0] s1,
      input logic [31:0] e2, input logic c2, input logic [1:0] s2, input logic st);
    vec_t r;
    r.pv = pv; r.pwr = pwr; r.prd = prd; r.v = v; r.fl = fl;
    r.a1 = a1; r.u1 = u1; r.a2 = a2; r.u2 = u2; r.ok = ok;
    r.e1 = e1; r.c1 = c1; r.s1 = s1; r.e2 = e2; r.c2 = c2; r.s2 = s2; r.st = st;
    return r;
  endfunction

  // Reference model state: m[k] describes the instruction in stage k.
  typedef struct packed { logic v; logic [4:0] rd; logic w; } ment_t;
  ment_t       m [NS];
  logic [31:0] mcnt;

  function automatic void ref_op(input logic [4:0] a, input logic u, input logic [31:0] rf,
                                 output logic [31:0] f, output logic [1:0] sel, output logic hz);
    f = rf; sel = 0; hz = 0;
    if (u && a != 0) begin
      for (int k = 0; k < NS; k++) begin
        if (m[k].v && m[k].w && m[k].rd == a) begin
          sel = 2'(k + 1);
          hz  = !stage_result_ok[k];
          f   = stage_result[k*32 +: 32];
          break;
        end
      end
    end
  endfunction

  vec_t vecs [12];

  initial begin
    vec_t        t;
    logic [31:0] f1, f2;
    logic [1:0]  s1, s2;
    logic        h1, h2, st;

    vecs[0]  = mk(3'b001, 3'b001, {5'd0, 5'd0, 5'd5}, 1, 0, 5, 1, 0, 0, 3'b111, 32'hA5,   1, 1, 32'h5678, 1, 0, 0);
    vecs[1]  = mk(3'b001, 3'b001, {5'd0, 5'd0, 5'd0}, 1, 0, 0, 1, 0, 0, 3'b111, 32'h1234, 1, 0, 32'h5678, 1, 0, 0);
    vecs[2]  = mk(3'b001, 3'b001, {5'd0, 5'd0, 5'd7}, 1, 0, 0, 0, 7, 0, 3'b000, 32'h1234, 1, 0, 32'h5678, 1, 0, 0);
    vecs[3]  = mk(3'b101, 3'b101, {5'd9, 5'd0, 5'd9}, 1, 0, 9, 1, 0, 0, 3'b111, 32'hA5,   1, 1, 32'h5678, 1, 0, 0);
    vecs[4]  = mk(3'b101, 3'b101, {5'd9, 5'd0, 5'd9}, 1, 0, 9, 1, 0, 0, 3'b100, 32'h0,    0, 1, 32'h5678, 1, 0, 1);
    vecs[5]  = mk(3'b110, 3'b110, {5'd4, 5'd3, 5'd0}, 1, 0, 3, 1, 4, 1, 3'b111, 32'h77,   1, 2, 32'h22,   1, 3, 0);
    vecs[6]  = mk(3'b110, 3'b110, {5'd4, 5'd3, 5'd0}, 1, 0, 3, 1, 4, 1, 3'b011, 32'h77,   1, 2, 32'h0,    0, 3, 1);
    vecs[7]  = mk(3'b110, 3'b110, {5'd4, 5'd3, 5'd0}, 0, 0, 3, 1, 4, 1, 3'b011, 32'h77,   1, 2, 32'h0,    0, 3, 0);
    vecs[8]  = mk(3'b110, 3'b110, {5'd4, 5'd3, 5'd0}, 1, 1, 3, 1, 4, 1, 3'b011, 32'h77,   1, 2, 32'h0,    0, 3, 0);
    vecs[9]  = mk(3'b001, 3'b000, {5'd0, 5'd0, 5'd5}, 1, 0, 5, 1, 0, 0, 3'b111, 32'h1234, 1, 0, 32'h5678, 1, 0, 0);
    vecs[10] = mk(3'b000, 3'b001, {5'd0, 5'd0, 5'd5}, 1, 0, 5, 1, 0, 0, 3'b111, 32'h1234, 1, 0, 32'h5678, 1, 0, 0);
    vecs[11] = mk(3'b010, 3'b010, {5'd0, 5'd5, 5'd0}, 1, 0, 5, 1, 5, 1, 3'b111, 32'h77,   1, 2, 32'h77,   1, 2, 0);

    idle();
    rstn = 0;
    @(negedge clk);

    // Reset state.
    id_rs1_data = 32'h1234;
    do_reset();
    #1;
    chk("reset rs1_fwd", rs1_fwd, 32'h1234);
    chk("reset rs2_fwd", rs2_fwd, 32'h5678);
    chk("reset sel1", 32'(fwd_sel1), 0);
    chk("reset stall", 32'(stall), 0);
    chk("reset stall_cycles", stall_cycles, 0);

    // Table vectors: build the pipe oldest-first, then hold it and probe decode.
    for (int i = 0; i < 12; i++) begin
      t = vecs[i];
      idle();
      do_reset();
      for (int s = NS - 1; s >= 0; s--) push(t.pv[s], t.prd[s*5 +: 5], t.pwr[s]);
      id_valid = t.v; flush = t.fl; stage_result_ok = t.ok;
      id_rs1_addr = t.a1; id_rs1_used = t.u1; id_rs2_addr = t.a2; id_rs2_used = t.u2;
      #1;
      if (t.c1) chk($sformatf("vec%0d rs1_fwd", i), rs1_fwd, t.e1);
      chk($sformatf("vec%0d sel1", i), 32'(fwd_sel1), 32'(t.s1));
      if (t.c2) chk($sformatf("vec%0d rs2_fwd", i), rs2_fwd, t.e2);
      chk($sformatf("vec%0d sel2", i), 32'(fwd_sel2), 32'(t.s2));
      chk($sformatf("vec%0d stall", i), 32'(stall), 32'(t.st));
      @(negedge clk);
    end

    // Load-use: one stall cycle, then forward from stage 1.
    idle();
    do_reset();
    push(1, 6, 1);
    id_valid = 1; id_rs2_addr = 6; id_rs2_used = 1; stage_result_ok = 3'b000; adv = 1;
    #1;
    chk("lu stall", 32'(stall), 1);
    chk("lu stall_cycles before", stall_cycles, 0);
    @(negedge clk);
    stage_result = {32'h22, 32'h77, 32'h0}; stage_result_ok = 3'b010;
    #1;
    chk("lu stall after", 32'(stall), 0);
    chk("lu stall_cycles", stall_cycles, 1);
    chk("lu rs2_fwd", rs2_fwd, 32'h77);
    chk("lu sel2", 32'(fwd_sel2), 2);
    @(negedge clk);

    // Flush during hazard: no stall, and the flushed slot leaves a bubble.
    idle();
    do_reset();
    push(1, 6, 1);
    id_valid = 1; id_rs2_addr = 6; id_rs2_used = 1; stage_result_ok = 3'b000;
    id_rd_addr = 8; id_reg_wr = 1; flush = 1; adv = 1;
    #1;
    chk("flush stall", 32'(stall), 0);
    @(negedge clk);
    adv = 0; flush = 0; stage_result_ok = 3'b111;
    id_rs1_addr = 8; id_rs1_used = 1;
    #1;
    chk("flush bubble sel1", 32'(fwd_sel1), 0);
    chk("flush old sel2", 32'(fwd_sel2), 2);
    chk("flush stall_cycles", stall_cycles, 0);
    @(negedge clk);

    // Randomized run against the reference model.
    idle();
    do_reset();
    for (int k = 0; k < NS; k++) m[k] = '0;
    mcnt = 0;
    for (int c = 0; c < 600; c++) begin
      rstn            = ($urandom_range(0, 39) != 0);
      id_valid        = ($urandom_range(0, 4) != 0);
      id_rs1_addr     = 5'($urandom_range(0, 3));
      id_rs2_addr     = 5'($urandom_range(0, 3));
      id_rs1_used     = 1'($urandom);
      id_rs2_used     = 1'($urandom);
      id_rd_addr      = 5'($urandom_range(0, 3));
      id_reg_wr       = 1'($urandom);
      id_rs1_data     = $urandom;
      id_rs2_data     = $urandom;
      stage_result    = {$urandom, $urandom, $urandom};
      stage_result_ok = 3'($urandom);
      adv             = ($urandom_range(0, 3) != 0);
      flush           = ($urandom_range(0, 9) == 0);
      #1;
      ref_op(id_rs1_addr, id_rs1_used, id_rs1_data, f1, s1, h1);
      ref_op(id_rs2_addr, id_rs2_used, id_rs2_data, f2, s2, h2);
      st = id_valid && !flush && (h1 || h2);
      if (!h1) chk($sformatf("rnd%0d rs1_fwd", c), rs1_fwd, f1);
      if (!h2) chk($sformatf("rnd%0d rs2_fwd", c), rs2_fwd, f2);
      chk($sformatf("rnd%0d sel1", c), 32'(fwd_sel1), 32'(s1));
      chk($sformatf("rnd%0d sel2", c), 32'(fwd_sel2), 32'(s2));
      chk($sformatf("rnd%0d stall", c), 32'(stall), 32'(st));
      chk($sformatf("rnd%0d stall_cycles", c), stall_cycles, mcnt);
      @(posedge clk);
      if (!rstn) begin
        for (int k = 0; k < NS; k++) m[k] = '0;
        mcnt = 0;
      end else begin
        if (st && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 1;
        if (adv) begin
          for (int k = NS - 1; k > 0; k--) m[k] = m[k-1];
          m[0] = '{v: id_valid && !st && !flush, rd: id_rd_addr, w: id_reg_wr};
        end
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

`default_nettype wire
